// File: rtl/bram_row_reader_pkg.sv
// Shared types and defaults for the BRAM row reader: FSM states, pixel word,
// and the beat that travels through the output FIFO.
package bram_row_reader_pkg;

    localparam int IMG_WIDTH_DEF = 640;
    localparam int MAX_ROWS_DEF  = 7;

    typedef logic [31:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rr_state_e;

    typedef struct packed {
        logic [2:0] row;
        logic       last;
        pixel_t     data;
    } rr_beat_t;

endpackage

// File: rtl/rr_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides and an occupancy count.
// Accepts a push while full if the head is popped in the same cycle.
module rr_skid_fifo #(
    parameter int W = 36
) (
    input  logic         clka,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt;
    logic              push, pop;

    assign out_valid = (cnt != 2'd0);
    assign in_ready  = (cnt != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;

    always_ff @(posedge clka) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/bram_row_reader.sv
// Streams a window of image rows out of a 1-cycle-latency BRAM, row-major,
// through a 2-entry FIFO with full throughput when the consumer is ready.
module bram_row_reader
    import bram_row_reader_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int MAX_ROWS  = MAX_ROWS_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [2:0]        window,
    output logic              ena,
    output logic [3:0]        wea,
    output logic [ADDR_W-1:0] addra,
    input  logic [31:0]       douta,
    output logic [31:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [2:0]        m_row,
    output logic              busy,
    output logic              done
);

    localparam int               COL_W      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_WIDTH - 1);
    localparam logic [2:0]       MAX_ROWS_3 = 3'(MAX_ROWS);

    rr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  col_q;
    logic [2:0]        row_q, rows_q;
    logic              inflight_q;
    logic [2:0]        tag_row_q;
    logic              tag_last_q;
    logic              done_q;

    logic [2:0]        eff_rows;
    logic              issue, start;
    logic              last_col, last_row;
    logic [2:0]        occ;
    logic              pop;
    logic [1:0]        fifo_cnt;
    logic              fifo_in_ready;
    rr_beat_t          in_beat, out_beat;

    assign eff_rows = (window > MAX_ROWS_3) ? MAX_ROWS_3 : window;
    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == rows_q - 3'd1);
    assign pop      = m_valid && m_ready;
    // Slots that will be taken once everything already requested has landed.
    assign occ      = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    start   = (eff_rows != 3'd0);
                    state_d = (eff_rows != 3'd0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                issue = (occ < 3'd2) && fifo_in_ready;
                if (issue && last_col && last_row)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_cnt == 2'd0 && !inflight_q)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= 3'd0;
            rows_q     <= 3'd0;
            inflight_q <= 1'b0;
            tag_row_q  <= 3'd0;
            tag_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Clearing inflight on reset drops the data of a read issued in the reset cycle.
            inflight_q <= issue;
            done_q     <= (state_q == ST_DONE);
            if (start) begin
                addr_q <= base_addr;
                col_q  <= '0;
                row_q  <= 3'd0;
                rows_q <= eff_rows;
            end else if (issue) begin
                addr_q     <= addr_q + ADDR_W'(1);
                tag_row_q  <= row_q;
                tag_last_q <= last_col;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 3'd1;
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    assign in_beat = '{row: tag_row_q, last: tag_last_q, data: douta};

    rr_skid_fifo #(.W($bits(rr_beat_t))) u_fifo (
        .clka      (clka),
        .reset     (reset),
        .in_data   (in_beat),
        .in_valid  (inflight_q),
        .in_ready  (fifo_in_ready),
        .out_data  (out_beat),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .count     (fifo_cnt)
    );

    assign ena    = issue;
    assign wea    = 4'b0000;
    assign addra  = addr_q;
    assign m_data = out_beat.data;
    assign m_last = out_beat.last;
    assign m_row  = out_beat.row;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

endmodule
